register_file_param: RTL and testbench
======================================

# register_file_param

Parametrised, multi-entry register file with two combinational read ports, one synchronous write port, optional write-to-read bypass, an optional hard-wired zero register, and a sequenced bulk-clear engine. It replaces the fixed 4×4 register file in the datapath and is sized by parameters. A small state machine zeroes one entry per cycle on request and reports busy and done status to the controlling logic.

## Interface
- WIDTH, 4: bits per entry, ≥1
- DEPTH, 4: number of entries, power of two, ≥2; ADDR_W = $clog2(DEPTH)
- ZERO_REG, 0: 1 → entry 0 always reads 0 and writes to it are discarded
- BYPASS, 1: 1 → a read of the address being written in the same cycle returns i_port_write
- i_clk  in  1  clock; single clock domain, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_reg_read_0  in  ADDR_W  read address, port 0
- i_reg_read_1  in  ADDR_W  read address, port 1
- i_reg_write  in  ADDR_W  write address
- i_port_write  in  WIDTH  write data
- i_write_enable  in  1  write strobe
- i_clear  in  1  bulk-clear request, level-sampled
- o_port_read_0  out  WIDTH  read data, port 0
- o_port_read_1  out  WIDTH  read data, port 1
- o_busy  out  1  high while a clear is in progress
- o_clear_done  out  1  one-cycle pulse when a clear completes

## Operation
- Reset (i_rst=1 at an edge): all entries ← 0, state ← IDLE, clear index ← 0, o_busy=0, o_clear_done=0. Reset overrides writes and clear.
- Write: at an edge with i_write_enable=1, o_busy=0 and i_rst=0, entry[i_reg_write] ← i_port_write. Writes while o_busy=1 are dropped, not queued.
- Read: purely combinational, o_port_read_n = entry[i_reg_read_n].
- Bypass (BYPASS=1): if i_write_enable=1, o_busy=0 and i_reg_read_n == i_reg_write, the port returns i_port_write. Ports 0 and 1 are evaluated independently.
- ZERO_REG=1: address 0 reads 0 on both ports regardless of bypass. Writes to address 0 have no effect.
- FSM states:
  - IDLE: i_clear=1 → CLEAR with index ← 0.
  - CLEAR: each cycle entry[index] ← 0 and index ← index+1. When index == DEPTH-1, return to IDLE.
- i_clear is ignored while in CLEAR. A request held high after completion starts a new clear.
- Reads are allowed during CLEAR and return current contents, i.e. partially cleared data.
- Index width is ADDR_W and wraps naturally; no extra terminal state.
- Reset in CLEAR aborts the clear immediately. No o_clear_done is issued.

## Timing
- Read latency 0 cycles. Written data is visible from storage in the cycle after the write edge; with BYPASS=1 it is visible in the same cycle.
- Clear: i_clear sampled at edge t, so o_busy=1 during cycles t+1 … t+DEPTH. Entry k is zeroed at edge t+1+k.
- o_clear_done=1 for exactly the single cycle after the last entry is zeroed, i.e. the first IDLE cycle. o_busy=0 in that cycle.
- Write accepted in the same cycle as an IDLE→CLEAR request: the write happens, then the clear sweep overwrites it.
- All outputs are registered except the read ports.

## Structure
- Shared package regfile_pkg: state enum typedef (IDLE, CLEAR) and the ADDR_W helper function.
- Sub-module register_en_n (parameter WIDTH): synchronous active-high reset and enable, one instance per entry via generate. Clear and write enables are muxed in the parent.
- Read muxes and bypass logic are inline in the parent. The decoder is generalised to ADDR_W→DEPTH one-hot.

## Test plan
- Reset, then write 0xA→r1, 0x5→r2 → read0=r1 gives 0xA and read1=r2 gives 0x5 from the next cycle; all other entries read 0.
- BYPASS=1: write 0x7→r3 while reading r3 on both ports → both ports show 0x7 in the same cycle. BYPASS=0 → both show the old value 0x0.
- ZERO_REG=1: write 0xF→r0 → r0 reads 0 on both ports, including the write cycle.
- Fill r0..r3 with 0x1..0x4, pulse i_clear → o_busy high 4 cycles; entries read 0 progressively, r0 first. o_clear_done pulses once, then o_busy=0. A write of 0x9→r2 issued mid-clear is dropped and r2 reads 0 afterwards.
- Assert i_rst in the 2nd CLEAR cycle → next cycle o_busy=0, o_clear_done=0, all entries 0, FSM accepts a new i_clear.
- DEPTH=8, WIDTH=16: write 0xBEEF→r7 then 0x1234→r0 → reads correct. Clear takes 8 busy cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the parametrised register file.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   // Address width for a given entry count; never narrower than one bit.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/register_en_n.sv
// Single register-file entry: synchronous active-high reset with load enable.
module register_en_n #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional bypass and zero register, plus a one-entry-per-cycle clear engine.
module register_file_param
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned DEPTH    = 4,
   parameter bit          ZERO_REG = 1'b0,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned ADDR_W  = addr_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_reg_read_0,
   input  logic [ADDR_W-1:0] i_reg_read_1,
   input  logic [ADDR_W-1:0] i_reg_write,
   input  logic [WIDTH-1:0]  i_port_write,
   input  logic              i_write_enable,
   input  logic              i_clear,
   output logic [WIDTH-1:0]  o_port_read_0,
   output logic [WIDTH-1:0]  o_port_read_1,
   output logic              o_busy,
   output logic              o_clear_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_e            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic              busy_nxt, done_nxt;

   logic              in_clear;
   logic              write_ok;
   logic [DEPTH-1:0]  wr_dec, clr_dec, wr_mask;
   logic [WIDTH-1:0]  entry_d;
   logic [WIDTH-1:0]  mem [DEPTH];

   // Clear FSM state, sweep index and status flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         idx          <= '0;
         o_busy       <= 1'b0;
         o_clear_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         o_busy       <= busy_nxt;
         o_clear_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (i_clear) begin
               state_nxt = CLEAR;
               idx_nxt   = '0;
            end
         end
         CLEAR: begin
            idx_nxt = idx + ADDR_W'(1);
            if (idx == LAST_IDX) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == CLEAR);
   end

   // Writes are refused for the whole sweep; o_busy mirrors the CLEAR state.
   assign in_clear = (state == CLEAR);
   assign write_ok = i_write_enable & ~o_busy;
   assign wr_dec   = DEPTH'(1) << i_reg_write;
   assign clr_dec  = DEPTH'(1) << idx;
   assign wr_mask  = ZERO_REG ? (wr_dec & ~DEPTH'(1)) : wr_dec;
   assign entry_d  = in_clear ? '0 : i_port_write;

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      logic en;
      assign en = (in_clear & clr_dec[g]) | (write_ok & wr_mask[g]);

      register_en_n #(.WIDTH(WIDTH)) u_reg (
         .clk (i_clk),
         .rst (i_rst),
         .en  (en),
         .d   (entry_d),
         .q   (mem[g])
      );
   end

   // Read muxes; zero register takes priority over bypass.
   always_comb begin
      o_port_read_0 = mem[i_reg_read_0];
      if (BYPASS && write_ok && (i_reg_read_0 == i_reg_write)) begin
         o_port_read_0 = i_port_write;
      end
      if (ZERO_REG && (i_reg_read_0 == '0)) begin
         o_port_read_0 = '0;
      end
   end

   always_comb begin
      o_port_read_1 = mem[i_reg_read_1];
      if (BYPASS && write_ok && (i_reg_read_1 == i_reg_write)) begin
         o_port_read_1 = i_port_write;
      end
      if (ZERO_REG && (i_reg_read_1 == '0)) begin
         o_port_read_1 = '0;
      end
   end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default, no-bypass, zero-register
// and 8x16 configurations driven side by side.
module tb_register_file_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ra0, ra1, wa;
   logic [3:0] wd;
   logic       we, clr;

   logic [3:0] rd0_d, rd1_d, rd0_n, rd1_n, rd0_z, rd1_z;
   logic       busy_d, done_d, busy_n, done_n, busy_z, done_z;

   logic [2:0]  ra0_w, ra1_w, wa_w;
   logic [15:0] wd_w, rd0_w, rd1_w;
   logic        we_w, clr_w, busy_w, done_w;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   register_file_param dut (
      .i_clk(clk), .i_rst(rst), .i_reg_read_0(ra0), .i_reg_read_1(ra1),
      .i_reg_write(wa), .i_port_write(wd), .i_write_enable(we), .i_clear(clr),
      .o_port_read_0(rd0_d), .o_port_read_1(rd1_d), .o_busy(busy_d),
      .o_clear_done(done_d));

   register_file_param #(.BYPASS(1'b0)) dut_nb (
      .i_clk(clk), .i_rst(rst), .i_reg_read_0(ra0), .i_reg_read_1(ra1),
      .i_reg_write(wa), .i_port_write(wd), .i_write_enable(we), .i_clear(clr),
      .o_port_read_0(rd0_n), .o_port_read_1(rd1_n), .o_busy(busy_n),
      .o_clear_done(done_n));

   register_file_param #(.ZERO_REG(1'b1)) dut_z (
      .i_clk(clk), .i_rst(rst), .i_reg_read_0(ra0), .i_reg_read_1(ra1),
      .i_reg_write(wa), .i_port_write(wd), .i_write_enable(we), .i_clear(clr),
      .o_port_read_0(rd0_z), .o_port_read_1(rd1_z), .o_busy(busy_z),
      .o_clear_done(done_z));

   register_file_param #(.WIDTH(16), .DEPTH(8)) dut_w (
      .i_clk(clk), .i_rst(rst), .i_reg_read_0(ra0_w), .i_reg_read_1(ra1_w),
      .i_reg_write(wa_w), .i_port_write(wd_w), .i_write_enable(we_w),
      .i_clear(clr_w), .o_port_read_0(rd0_w), .o_port_read_1(rd1_w),
      .o_busy(busy_w), .o_clear_done(done_w));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; ra0 = '0; ra1 = '0; wa = '0; wd = '0; we = 1'b0; clr = 1'b0;
      ra0_w = '0; ra1_w = '0; wa_w = '0; wd_w = '0; we_w = 1'b0; clr_w = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      #1;
      check("reset_busy", 32'(busy_d), 32'h0);
      check("reset_done", 32'(done_d), 32'h0);
      for (int k = 0; k < 4; k++) begin
         ra0 = 2'(k);
         #1;
         check("reset_entry", 32'(rd0_d), 32'h0);
      end

      // Basic writes and reads
      we = 1'b1; wa = 2'd1; wd = 4'hA;
      tick;
      wa = 2'd2; wd = 4'h5;
      tick;
      we = 1'b0; ra0 = 2'd1; ra1 = 2'd2;
      #1;
      check("read0_r1", 32'(rd0_d), 32'hA);
      check("read1_r2", 32'(rd1_d), 32'h5);
      ra0 = 2'd0; ra1 = 2'd3;
      #1;
      check("read0_r0", 32'(rd0_d), 32'h0);
      check("read1_r3", 32'(rd1_d), 32'h0);

      // Same-cycle bypass vs. storage read
      we = 1'b1; wa = 2'd3; wd = 4'h7; ra0 = 2'd3; ra1 = 2'd3;
      #1;
      check("byp_p0", 32'(rd0_d), 32'h7);
      check("byp_p1", 32'(rd1_d), 32'h7);
      check("nobyp_p0", 32'(rd0_n), 32'h0);
      check("nobyp_p1", 32'(rd1_n), 32'h0);
      tick;
      we = 1'b0;
      #1;
      check("nobyp_after", 32'(rd0_n), 32'h7);

      // Zero register ignores writes, even in the write cycle
      we = 1'b1; wa = 2'd0; wd = 4'hF; ra0 = 2'd0; ra1 = 2'd0;
      #1;
      check("zero_p0_wcyc", 32'(rd0_z), 32'h0);
      check("zero_p1_wcyc", 32'(rd1_z), 32'h0);
      check("byp_r0_wcyc", 32'(rd0_d), 32'hF);
      tick;
      we = 1'b0;
      #1;
      check("zero_p0_after", 32'(rd0_z), 32'h0);
      check("r0_after", 32'(rd0_d), 32'hF);

      // Fill r0..r3 with 1..4, then sweep-clear
      for (int k = 0; k < 4; k++) begin
         we = 1'b1; wa = 2'(k); wd = 4'(k + 1);
         tick;
      end
      we = 1'b0;
      clr = 1'b1;
      tick;
      clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ra0 = 2'(k); ra1 = 2'd2;
         #1;
         check("clr_busy", 32'(busy_d), 32'h1);
         check("clr_done_low", 32'(done_d), 32'h0);
         check("clr_pre", 32'(rd0_d), 32'(k + 1));
         if (k == 1) begin
            we = 1'b1; wa = 2'd2; wd = 4'h9;
            #1;
            check("clr_no_bypass", 32'(rd1_d), 32'h3);
         end
         tick;
         we = 1'b0;
         #1;
         check("clr_post", 32'(rd0_d), 32'h0);
      end
      check("clr_end_busy", 32'(busy_d), 32'h0);
      check("clr_end_done", 32'(done_d), 32'h1);
      tick;
      check("clr_done_once", 32'(done_d), 32'h0);
      ra0 = 2'd2;
      #1;
      check("clr_r2_dropped", 32'(rd0_d), 32'h0);

      // Reset during the second CLEAR cycle aborts the sweep
      we = 1'b1; wa = 2'd3; wd = 4'h6;
      tick;
      we = 1'b0;
      clr = 1'b1;
      tick;
      clr = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      check("abort_busy", 32'(busy_d), 32'h0);
      check("abort_done", 32'(done_d), 32'h0);
      for (int k = 0; k < 4; k++) begin
         ra0 = 2'(k);
         #1;
         check("abort_entry", 32'(rd0_d), 32'h0);
      end
      clr = 1'b1;
      tick;
      clr = 1'b0;
      check("restart_busy", 32'(busy_d), 32'h1);
      n = 0;
      while (busy_d && n < 20) begin
         n++;
         tick;
      end
      check("restart_cycles", 32'(n), 32'd4);
      check("restart_done", 32'(done_d), 32'h1);

      // Wide configuration
      we_w = 1'b1; wa_w = 3'd7; wd_w = 16'hBEEF;
      tick;
      wa_w = 3'd0; wd_w = 16'h1234;
      tick;
      we_w = 1'b0; ra0_w = 3'd7; ra1_w = 3'd0;
      #1;
      check("wide_r7", 32'(rd0_w), 32'hBEEF);
      check("wide_r0", 32'(rd1_w), 32'h1234);
      clr_w = 1'b1;
      tick;
      clr_w = 1'b0;
      n = 0;
      while (busy_w && n < 20) begin
         n++;
         tick;
      end
      check("wide_clr_cycles", 32'(n), 32'd8);
      check("wide_clr_done", 32'(done_w), 32'h1);
      #1;
      check("wide_r7_cleared", 32'(rd0_w), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
